// File: rtl/bus_interface_if.sv
// bus_interface_if: groups the CPU-side and memory-side signals of bus_interface.
//   master : view used by bus_interface (drives data_in/data_valid/opcode_fetch/
//            stall/bus_error toward the CPU and mem_* toward memory)
//   slave  : view used by the surrounding CPU/memory environment
// Signals:
//   cpu_addr[15:0], cpu_wdata[7:0], cpu_rd, cpu_wr, cpu_sync, err_clr  (CPU requests)
//   data_in[7:0], data_valid, opcode_fetch, stall, bus_error           (CPU responses)
//   mem_addr[15:0], mem_wdata[7:0], mem_req, mem_we                    (memory request)
//   mem_rdata[7:0], mem_ready                                          (memory response)
interface bus_interface_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rd;
  logic        cpu_wr;
  logic        cpu_sync;
  logic        err_clr;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        opcode_fetch;
  logic        stall;
  logic        bus_error;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr, cpu_sync, err_clr,
    input  mem_rdata, mem_ready,
    output data_in, data_valid, opcode_fetch, stall, bus_error,
    output mem_addr, mem_wdata, mem_req, mem_we
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_rd, cpu_wr, cpu_sync, err_clr,
    output mem_rdata, mem_ready,
    input  data_in, data_valid, opcode_fetch, stall, bus_error,
    input  mem_addr, mem_wdata, mem_req, mem_we
  );
endinterface

// File: rtl/bus_interface.sv
// bus_interface: single-outstanding CPU-to-memory access sequencer.
//   A read/write request seen in IDLE is latched and presented to memory
//   (ACCESS) until mem_ready; reads return data_in with a one-cycle data_valid
//   pulse. Too many not-ready cycles park the block in ERROR (sticky bus_error)
//   until err_clr.
// Ports:
//   ph1   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : bus_interface_if.master (CPU and memory signal groups)
// Parameter:
//   TIMEOUT_CYCLES : not-ready ACCESS cycles tolerated before ERROR (1..255)
module bus_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic            ph1,
  input  logic            reset,
  bus_interface_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERROR  = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        we_q;
  logic        sync_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        opf_q;
  logic        err_q;

  logic        req_start;
  logic        timeout_hit;

  assign req_start   = (state_q == IDLE) && (bus.cpu_rd || bus.cpu_wr);
  // mem_ready is excluded here so a completion on the timeout edge wins.
  assign timeout_hit = (state_q == ACCESS) && !bus.mem_ready &&
                       (wait_cnt_q == TIMEOUT_LAST);

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_start) state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.mem_ready)    state_d = IDLE;
        else if (timeout_hit) state_d = ERROR;
      end
      ERROR: begin
        if (bus.err_clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      sync_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      opf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      opf_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_start) begin
            addr_q     <= bus.cpu_addr;
            wdata_q    <= bus.cpu_wdata;
            sync_q     <= bus.cpu_sync;
            // write wins when both rd and wr are requested
            we_q       <= bus.cpu_wr;
            wait_cnt_q <= '0;
          end
        end
        ACCESS: begin
          if (bus.mem_ready) begin
            if (!we_q) begin
              data_q  <= bus.mem_rdata;
              valid_q <= 1'b1;
              opf_q   <= sync_q;
            end
          end else begin
            if (wait_cnt_q != '1) wait_cnt_q <= wait_cnt_q + 8'd1;
            if (timeout_hit)      err_q      <= 1'b1;
          end
        end
        ERROR: begin
          if (bus.err_clr) err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.stall        = (state_q != IDLE);
  assign bus.mem_req      = (state_q == ACCESS);
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_we       = we_q;
  assign bus.data_in      = data_q;
  assign bus.data_valid   = valid_q;
  assign bus.opcode_fetch = opf_q;
  assign bus.bus_error    = err_q;

endmodule

// File: doc/bus_interface.md
BUS_INTERFACE -- requirements
Module: bus_interface

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 15, number of consecutive not-ready access cycles tolerated before a bus error; legal range 1..255.
REQ-002 ph1  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_addr  input  16  CPU access address.
REQ-005 cpu_wdata  input  8  CPU write data.
REQ-006 cpu_rd  input  1  read request, sampled only in IDLE.
REQ-007 cpu_wr  input  1  write request, sampled only in IDLE.
REQ-008 cpu_sync  input  1  marks the request as an opcode fetch.
REQ-009 err_clr  input  1  clears the ERROR state.
REQ-010 data_in  output  8  read data delivered to the control unit.
REQ-011 data_valid  output  1  one-cycle pulse: data_in was updated.
REQ-012 opcode_fetch  output  1  qualifies data_valid as an opcode byte.
REQ-013 stall  output  1  CPU must hold; high whenever state is not IDLE.
REQ-014 bus_error  output  1  sticky timeout flag.
REQ-015 mem_addr  output  16  memory address.
REQ-016 mem_wdata  output  8  memory write data.
REQ-017 mem_req  output  1  memory access request.
REQ-018 mem_we  output  1  write enable, valid while mem_req=1.
REQ-019 mem_rdata  input  8  memory read data.
REQ-020 mem_ready  input  1  memory completes the access this cycle.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, ACCESS and ERROR.
REQ-022 In IDLE, an edge with cpu_rd|cpu_wr=1 SHALL register cpu_addr, cpu_wdata, cpu_sync and we=cpu_wr, clear the wait counter, and enter ACCESS.
REQ-023 When cpu_rd and cpu_wr are both high in IDLE, the block SHALL perform a write and ignore the read.
REQ-024 mem_req SHALL be 1 only in ACCESS, and mem_addr, mem_we and mem_wdata SHALL hold the registered values, stable for the entire ACCESS period.
REQ-025 In ACCESS, an edge with mem_ready=1 SHALL return the FSM to IDLE.
REQ-026 For a read, that same edge SHALL load data_in<=mem_rdata, pulse data_valid for exactly one cycle, and set opcode_fetch to the registered sync bit for that cycle.
REQ-027 A write completion SHALL produce no data_valid pulse and SHALL leave data_in unchanged.
REQ-028 Zero-wait latency SHALL be exactly two edges: the request edge N, the ready edge N+1, with data_valid high after N+1.
REQ-029 Each ACCESS edge with mem_ready=0 SHALL increment the wait counter (8 bits, saturating).
REQ-030 An ACCESS edge with mem_ready=0 and counter==TIMEOUT_CYCLES-1 SHALL enter ERROR, set bus_error=1, and drop mem_req.
REQ-031 If mem_ready=1 arrives on the timeout edge, completion SHALL take priority and no error is raised.
REQ-032 In ERROR, stall SHALL be 1 and mem_req SHALL be 0.
REQ-033 An ERROR edge with err_clr=1 SHALL return to IDLE and clear bus_error; err_clr SHALL be ignored in all other states.
REQ-034 cpu_rd, cpu_wr and cpu_sync SHALL be ignored outside IDLE; no request queueing.
REQ-035 stall SHALL be a decode of registered state only, with no combinational path from cpu_* inputs.
REQ-036 data_in SHALL hold its last read value between accesses.
REQ-037 opcode_fetch SHALL be 0 whenever data_valid=0.

Reset
REQ-038 reset=1 SHALL asynchronously force IDLE, counter=0, data_in=8'h00, data_valid=0, opcode_fetch=0, stall=0, bus_error=0, mem_req=0, mem_we=0, mem_addr=16'h0000, mem_wdata=8'h00.
REQ-039 reset asserted mid-ACCESS SHALL drop mem_req in the same cycle, with no data_valid pulse.

Verification
REQ-040 Zero-wait read: cpu_rd=1, cpu_sync=1, addr 16'h1234; mem_ready=1, mem_rdata=8'hA9 in the ACCESS cycle -> mem_req high one cycle at 16'h1234; then data_in=8'hA9, data_valid=1, opcode_fetch=1 for one cycle; stall high one cycle.
REQ-041 Three-wait-state write: cpu_wr=1, addr 16'h0200, wdata 8'h5C; mem_ready low 3 cycles then high -> mem_req/mem_we high 4 cycles with stable addr/data; no data_valid pulse; data_in unchanged.
REQ-042 Timeout: TIMEOUT_CYCLES=4, mem_ready stuck 0 -> ERROR after 4 ACCESS cycles, bus_error=1, mem_req=0, stall held; err_clr=1 -> IDLE, bus_error=0.
REQ-043 Simultaneous events: mem_ready=1 on the 4th cycle with TIMEOUT_CYCLES=4 -> normal completion, bus_error=0; cpu_rd=cpu_wr=1 -> mem_we=1.
REQ-044 Reset mid-access: assert reset during a waited read -> mem_req=0 and stall=0 immediately, all outputs at reset values, no data_valid.
